pixel_bank_buffer: RTL and testbench

PIXEL_BANK_BUFFER -- requirements
Module: pixel_bank_buffer

---
 rtl/pixel_bank_buffer_if.sv | 29 ++
 rtl/pixel_bank_buffer.sv | 114 +++++++++++
 tb/tb_pixel_bank_buffer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/pixel_bank_buffer_if.sv
// Bundle of write, read and bank-swap handshake signals for pixel_bank_buffer.
interface pixel_bank_buffer_if #(
    parameter int unsigned CW = 8,
    parameter int unsigned AW = 20
);
    logic              we;
    logic [AW-1:0]     waddr;
    logic [3*CW-1:0]   wdata;
    logic              re;
    logic [AW-1:0]     raddr;
    logic [CW-1:0]     r;
    logic [CW-1:0]     g;
    logic [CW-1:0]     b;
    logic              rvalid;
    logic              swap_req;
    logic              swap_ack;
    logic              wr_bank;
    logic              err;

    modport master (
        output we, waddr, wdata, re, raddr, swap_req,
        input  r, g, b, rvalid, swap_ack, wr_bank, err
    );

    modport slave (
        input  we, waddr, wdata, re, raddr, swap_req,
        output r, g, b, rvalid, swap_ack, wr_bank, err
    );
endinterface

// File: rtl/pixel_bank_buffer.sv
// Double-buffered pixel store: one bank written while the other is read, exchanged on request.
// Define PIXBUF_RANGE_ERR_EN to build the sticky out-of-range err flag; otherwise err is 0.
module pixel_bank_buffer #(
    parameter int unsigned CW    = 8,
    parameter int unsigned DEPTH = 10000,
    parameter int unsigned AW    = 20
) (
    input logic               clk,
    input logic               reset,
    pixel_bank_buffer_if.slave bus
);
    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] PEND = 1'b1;

    logic [3*CW-1:0] bank0 [DEPTH];
    logic [3*CW-1:0] bank1 [DEPTH];

    logic [0:0]      state_q, state_d;
    logic            wr_bank_q;
    logic            swap_ack_q;
    logic            rvalid_q;
    logic [3*CW-1:0] rgb_q;
    logic            swap_fire;

    logic            w_ok, r_ok;
    logic [IW-1:0]   widx, ridx;

    assign w_ok = 32'(bus.waddr) < DEPTH;
    assign r_ok = 32'(bus.raddr) < DEPTH;
    assign widx = bus.waddr[IW-1:0];
    assign ridx = bus.raddr[IW-1:0];

    // Memory has no reset; reset only blocks the write.
    always_ff @(posedge clk) begin
        if (reset && bus.we && w_ok) begin
            if (wr_bank_q) begin
                bank1[widx] <= bus.wdata;
            end else begin
                bank0[widx] <= bus.wdata;
            end
        end
    end

    // The exchange waits in PEND for a cycle with no traffic so no access straddles banks.
    always_comb begin
        state_d   = state_q;
        swap_fire = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.swap_req) begin
                    state_d = PEND;
                end
            end
            PEND: begin
                if (!bus.we && !bus.re) begin
                    swap_fire = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            wr_bank_q  <= 1'b0;
            swap_ack_q <= 1'b0;
            rvalid_q   <= 1'b0;
            rgb_q      <= '0;
        end else begin
            state_q    <= state_d;
            swap_ack_q <= swap_fire;
            rvalid_q   <= bus.re;
            if (swap_fire) begin
                wr_bank_q <= ~wr_bank_q;
            end
            if (bus.re) begin
                if (!r_ok) begin
                    rgb_q <= '0;
                end else if (wr_bank_q) begin
                    rgb_q <= bank0[ridx];
                end else begin
                    rgb_q <= bank1[ridx];
                end
            end
        end
    end

`ifdef PIXBUF_RANGE_ERR_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if ((bus.we && !w_ok) || (bus.re && !r_ok)) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.r        = rgb_q[CW-1:0];
    assign bus.g        = rgb_q[2*CW-1:CW];
    assign bus.b        = rgb_q[3*CW-1:2*CW];
    assign bus.rvalid   = rvalid_q;
    assign bus.swap_ack = swap_ack_q;
    assign bus.wr_bank  = wr_bank_q;
endmodule

// File: tb/tb_pixel_bank_buffer.sv
// Self-checking bench for pixel_bank_buffer: per-cycle model comparison plus directed literal checks.
module tb_pixel_bank_buffer;
    localparam int unsigned CW    = 10;
    localparam int unsigned DEPTH = 64;
    localparam int unsigned AW    = 8;
`ifdef PIXBUF_RANGE_ERR_EN
    localparam bit ErrEn = 1'b1;
`else
    localparam bit ErrEn = 1'b0;
`endif

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    pixel_bank_buffer_if #(.CW(CW), .AW(AW)) bus ();

    pixel_bank_buffer #(.CW(CW), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [29:0] pix(input logic [9:0] bb, input logic [9:0] gg,
                                        input logic [9:0] rr);
        return {bb, gg, rr};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: two arrays indexed by bank, a pending flag, and expected outputs.
    logic [29:0] m_mem [2][DEPTH];
    logic        m_wr, m_pend, m_ack, m_rvalid, m_err, m_live;
    logic [9:0]  m_r, m_g, m_b;

    initial begin
        m_live = 1'b0;
        for (int k = 0; k < 2; k++) begin
            for (int a = 0; a < int'(DEPTH); a++) m_mem[k][a] = '0;
        end
    end

    always @(posedge clk) begin
        if (!reset) begin
            m_wr <= 1'b0; m_pend <= 1'b0; m_ack <= 1'b0; m_rvalid <= 1'b0; m_err <= 1'b0;
            m_r <= '0; m_g <= '0; m_b <= '0;
            m_live <= 1'b1;
        end else begin
            if (bus.we && int'(bus.waddr) < int'(DEPTH)) m_mem[m_wr][bus.waddr[5:0]] <= bus.wdata;
            m_rvalid <= bus.re;
            if (bus.re) begin
                if (int'(bus.raddr) < int'(DEPTH)) {m_b, m_g, m_r} <= m_mem[!m_wr][bus.raddr[5:0]];
                else {m_b, m_g, m_r} <= '0;
            end
            if (m_pend && !bus.we && !bus.re) begin
                m_ack <= 1'b1; m_wr <= !m_wr; m_pend <= 1'b0;
            end else begin
                m_ack <= 1'b0;
                if (bus.swap_req) m_pend <= 1'b1;
            end
            if (ErrEn && ((bus.we && int'(bus.waddr) >= int'(DEPTH)) ||
                          (bus.re && int'(bus.raddr) >= int'(DEPTH)))) m_err <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("cyc_r", 32'(bus.r), 32'(m_r));
            check("cyc_g", 32'(bus.g), 32'(m_g));
            check("cyc_b", 32'(bus.b), 32'(m_b));
            check("cyc_rvalid", 32'(bus.rvalid), 32'(m_rvalid));
            check("cyc_swap_ack", 32'(bus.swap_ack), 32'(m_ack));
            check("cyc_wr_bank", 32'(bus.wr_bank), 32'(m_wr));
            check("cyc_err", 32'(bus.err), 32'(m_err));
        end
    end

    task automatic step(input logic rst_n, input logic w, input logic [7:0] wa,
                        input logic [29:0] wd, input logic rd, input logic [7:0] ra,
                        input logic sr);
        reset        = rst_n;
        bus.we       = w;
        bus.waddr    = wa;
        bus.wdata    = wd;
        bus.re       = rd;
        bus.raddr    = ra;
        bus.swap_req = sr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 8'd0, 30'd0, 1'b0, 8'd0, 1'b0);
    endtask

    task automatic swap();
        step(1'b1, 1'b0, 8'd0, 30'd0, 1'b0, 8'd0, 1'b1);
        idle();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        step(1'b0, 1'b0, 8'd0, 30'd0, 1'b0, 8'd0, 1'b0);
        step(1'b0, 1'b0, 8'd0, 30'd0, 1'b0, 8'd0, 1'b0);
        check("rst_rvalid", 32'(bus.rvalid), 32'd0);
        check("rst_wr_bank", 32'(bus.wr_bank), 32'd0);
        check("rst_r", 32'(bus.r), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);

        // Basic write, idle-cycle swap, read back.
        step(1'b1, 1'b1, 8'd5, pix(10'h33, 10'h22, 10'h11), 1'b0, 8'd0, 1'b0);
        step(1'b1, 1'b0, 8'd0, 30'd0, 1'b0, 8'd0, 1'b1);
        check("req_no_ack", 32'(bus.swap_ack), 32'd0);
        idle();
        check("ack_pulse", 32'(bus.swap_ack), 32'd1);
        check("ack_wr_bank", 32'(bus.wr_bank), 32'd1);
        step(1'b1, 1'b0, 8'd0, 30'd0, 1'b1, 8'd5, 1'b0);
        check("rd5_r", 32'(bus.r), 32'h11);
        check("rd5_g", 32'(bus.g), 32'h22);
        check("rd5_b", 32'(bus.b), 32'h33);
        check("rd5_rvalid", 32'(bus.rvalid), 32'd1);

        // Swap deferred by continuous writes; extra swap_req in PEND ignored.
        step(1'b1, 1'b1, 8'd7, pix(10'h077, 10'h066, 10'h055), 1'b0, 8'd0, 1'b1);
        for (int a = 10; a < 14; a++) begin
            step(1'b1, 1'b1, 8'(a), pix(10'(a + 2), 10'(a + 1), 10'(a)), 1'b0, 8'd0, 1'b1);
            check("busy_no_ack", 32'(bus.swap_ack), 32'd0);
        end
        idle();
        check("late_ack", 32'(bus.swap_ack), 32'd1);
        check("late_wr_bank", 32'(bus.wr_bank), 32'd0);
        idle();
        check("no_reswap", 32'(bus.swap_ack), 32'd0);
        for (int a = 10; a < 14; a++) begin
            step(1'b1, 1'b0, 8'd0, 30'd0, 1'b1, 8'(a), 1'b0);
            check("old_bank_r", 32'(bus.r), 32'(a));
            check("old_bank_b", 32'(bus.b), 32'(a + 2));
        end

        // Same-cycle write and read at one address hit different banks.
        step(1'b1, 1'b1, 8'd7, pix(10'h0AA, 10'h0BB, 10'h0CC), 1'b1, 8'd7, 1'b0);
        check("coll_r", 32'(bus.r), 32'h055);
        check("coll_b", 32'(bus.b), 32'h077);
        swap();
        step(1'b1, 1'b0, 8'd0, 30'd0, 1'b1, 8'd7, 1'b0);
        check("new7_r", 32'(bus.r), 32'h0CC);
        check("new7_g", 32'(bus.g), 32'h0BB);
        check("new7_b", 32'(bus.b), 32'h0AA);

        // Out-of-range write dropped (64 aliases 0 if truncated), out-of-range read returns 0.
        step(1'b1, 1'b1, 8'd0, pix(10'h1AB, 10'h1CD, 10'h1EF), 1'b0, 8'd0, 1'b0);
        step(1'b1, 1'b1, 8'd64, pix(10'h3FF, 10'h3FF, 10'h3FF), 1'b1, 8'd100, 1'b0);
        check("oob_r", 32'(bus.r), 32'd0);
        check("oob_b", 32'(bus.b), 32'd0);
        check("oob_rvalid", 32'(bus.rvalid), 32'd1);
        check("oob_err", 32'(bus.err), 32'(ErrEn));
        step(1'b1, 1'b1, 8'd255, pix(10'h3FF, 10'h3FF, 10'h3FF), 1'b0, 8'd0, 1'b0);
        swap();
        step(1'b1, 1'b0, 8'd0, 30'd0, 1'b1, 8'd0, 1'b0);
        check("oob_kept_r", 32'(bus.r), 32'h1EF);
        check("oob_kept_b", 32'(bus.b), 32'h1AB);

        // Reset while a swap is pending and rvalid is high.
        step(1'b1, 1'b0, 8'd0, 30'd0, 1'b0, 8'd0, 1'b1);
        step(1'b1, 1'b0, 8'd0, 30'd0, 1'b1, 8'd7, 1'b0);
        check("pend_rvalid", 32'(bus.rvalid), 32'd1);
        step(1'b0, 1'b1, 8'd7, pix(10'h3FF, 10'h3FF, 10'h3FF), 1'b1, 8'd7, 1'b1);
        check("prst_rvalid", 32'(bus.rvalid), 32'd0);
        check("prst_wr_bank", 32'(bus.wr_bank), 32'd0);
        check("prst_r", 32'(bus.r), 32'd0);
        check("prst_err", 32'(bus.err), 32'd0);
        idle();
        check("prst_no_ack", 32'(bus.swap_ack), 32'd0);
        step(1'b1, 1'b0, 8'd0, 30'd0, 1'b1, 8'd7, 1'b0);
        check("prst_keep_r", 32'(bus.r), 32'h055);
        swap();
        step(1'b1, 1'b0, 8'd0, 30'd0, 1'b1, 8'd7, 1'b0);
        check("prst_keep2_r", 32'(bus.r), 32'h0CC);

        // Full-width channels at the top address.
        step(1'b1, 1'b1, 8'd63, pix(10'h3FF, 10'h200, 10'h001), 1'b0, 8'd0, 1'b0);
        swap();
        step(1'b1, 1'b0, 8'd0, 30'd0, 1'b1, 8'd63, 1'b0);
        check("wide_r", 32'(bus.r), 32'h001);
        check("wide_g", 32'(bus.g), 32'h200);
        check("wide_b", 32'(bus.b), 32'h3FF);
        idle();
        idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
